// File: rtl/fish_pkg.sv
// fish_pkg: shared definitions for the fish sprite controller.
//   - FSM state encoding (IDLE, SWIM_R, SWIM_L, HOOKED)
//   - sprite geometry (32 x 16) and the transparent background colour
//   - coordinate width used for pixel and position values
package fish_pkg;

  localparam int COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  localparam int SPRITE_W = 32;
  localparam int SPRITE_H = 16;

  // ROM art uses pure white as the see-through background.
  localparam logic [11:0] TRANSPARENT = 12'hFFF;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SWIM_R = 2'd1;
  localparam logic [1:0] ST_SWIM_L = 2'd2;
  localparam logic [1:0] ST_HOOKED = 2'd3;

endpackage

// File: rtl/fish_motion_fsm.sv
// fish_motion_fsm: owns the fish state and sprite position.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   enable            - game running; low returns to IDLE with respawn position
//   caught            - one-cycle pulse, hook touched the fish
//   frame_tick        - one-cycle pulse per frame; all motion happens on it
//   state             - current FSM state (fish_pkg ST_* encoding)
//   fish_x, fish_y    - sprite top-left corner
module fish_motion_fsm
  import fish_pkg::*;
#(
  parameter coord_t     X_MIN     = 10'd0,
  parameter coord_t     X_MAX     = 10'd608,
  parameter coord_t     Y_START   = 10'd240,
  parameter coord_t     Y_SURFACE = 10'd32,
  parameter logic [3:0] SPEED     = 4'd2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       caught,
  input  logic       frame_tick,
  output logic [1:0] state,
  output coord_t     fish_x,
  output coord_t     fish_y
);

  localparam coord_t STEP = coord_t'(SPEED);

  // One extra bit so the right-edge test cannot wrap near the top of range.
  logic [COORD_W:0] x_fwd;
  assign x_fwd = {1'b0, fish_x} + {1'b0, STEP};

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      state  <= ST_IDLE;
      fish_x <= X_MIN;
      fish_y <= Y_START;
    end else begin
      case (state)
        ST_IDLE: begin
          // The launching tick already counts as the first move.
          if (frame_tick) begin
            state  <= ST_SWIM_R;
            fish_x <= X_MIN + STEP;
          end
        end
        ST_SWIM_R: begin
          // caught outranks frame_tick: the fish freezes where it is.
          if (caught) begin
            state <= ST_HOOKED;
          end else if (frame_tick) begin
            if (x_fwd >= {1'b0, X_MAX}) begin
              fish_x <= X_MAX;
              state  <= ST_SWIM_L;
            end else begin
              fish_x <= x_fwd[COORD_W-1:0];
            end
          end
        end
        ST_SWIM_L: begin
          if (caught) begin
            state <= ST_HOOKED;
          end else if (frame_tick) begin
            // Clamp before subtracting so fish_x never underflows.
            if (fish_x <= X_MIN + STEP) begin
              fish_x <= X_MIN;
              state  <= ST_SWIM_R;
            end else begin
              fish_x <= fish_x - STEP;
            end
          end
        end
        ST_HOOKED: begin
          if (frame_tick) begin
            if (fish_y <= Y_SURFACE + STEP) begin
              state  <= ST_IDLE;
              fish_x <= X_MIN;
              fish_y <= Y_START;
            end else begin
              fish_y <= fish_y - STEP;
            end
          end
        end
        default: begin
          state  <= ST_IDLE;
          fish_x <= X_MIN;
          fish_y <= Y_START;
        end
      endcase
    end
  end

endmodule

// File: rtl/fish_sprite_ctrl.sv
// fish_sprite_ctrl: fish sprite sequencer for the VGA pixel pipeline.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   enable, caught      - game running flag, hook-hit pulse
//   frame_tick          - one pulse per frame (start of vblank)
//   video_on, x, y      - active-video flag and current pixel coordinate
//   rom_row, rom_col    - combinational address to the external 32x16 ROM
//   rom_data            - ROM colour, valid one cycle after the address
//   fish_on, rgb        - registered opaque-pixel flag and colour
//   fish_x, fish_y      - sprite top-left corner
//   state               - motion FSM state
// Pixel outputs lag x/y by two cycles: stage 1 runs beside the ROM's own
// address register, stage 2 gates the returned colour.
module fish_sprite_ctrl
  import fish_pkg::*;
#(
  parameter coord_t     X_MIN     = 10'd0,
  parameter coord_t     X_MAX     = 10'd608,
  parameter coord_t     Y_START   = 10'd240,
  parameter coord_t     Y_SURFACE = 10'd32,
  parameter logic [3:0] SPEED     = 4'd2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        caught,
  input  logic        frame_tick,
  input  logic        video_on,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  output logic [3:0]  rom_row,
  output logic [4:0]  rom_col,
  input  logic [11:0] rom_data,
  output logic        fish_on,
  output logic [11:0] rgb,
  output logic [9:0]  fish_x,
  output logic [9:0]  fish_y,
  output logic [1:0]  state
);

  fish_motion_fsm #(
    .X_MIN     (X_MIN),
    .X_MAX     (X_MAX),
    .Y_START   (Y_START),
    .Y_SURFACE (Y_SURFACE),
    .SPEED     (SPEED)
  ) u_motion (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .caught     (caught),
    .frame_tick (frame_tick),
    .state      (state),
    .fish_x     (fish_x),
    .fish_y     (fish_y)
  );

  // Stage 0: box test and ROM addressing.
  coord_t dx;
  coord_t dy;
  logic   in_box;

  assign dx = x - fish_x;
  assign dy = y - fish_y;

  // The x >= fish_x terms reject pixels left/above the sprite, where the
  // unsigned difference would wrap to a large value anyway.
  assign in_box = (x >= fish_x) && (dx < coord_t'(SPRITE_W)) &&
                  (y >= fish_y) && (dy < coord_t'(SPRITE_H));

  assign rom_row = dy[3:0];
  // ROM art faces left, so mirror it whenever the fish is not swimming left.
  assign rom_col = (state == ST_SWIM_L) ? dx[4:0] : (5'd31 - dx[4:0]);

  // Stage 1 flags, aligned with the ROM output.
  logic in_box_d;
  logic video_on_d;
  logic pix_on;

  assign pix_on = in_box_d && video_on_d && (state != ST_IDLE) &&
                  (rom_data != TRANSPARENT);

  always_ff @(posedge clk) begin
    if (reset) begin
      in_box_d   <= 1'b0;
      video_on_d <= 1'b0;
      fish_on    <= 1'b0;
      rgb        <= 12'h000;
    end else begin
      in_box_d   <= in_box;
      video_on_d <= video_on;
      fish_on    <= pix_on;
      rgb        <= pix_on ? rom_data : 12'h000;
    end
  end

endmodule

// File: tb/tb_fish_sprite_ctrl.sv
// tb_fish_sprite_ctrl: self-checking bench for fish_sprite_ctrl.
// A behavioural ROM answers one cycle after the address; pixel expectations
// are pushed to a queue when a pixel is driven and popped two cycles later.
module tb_fish_sprite_ctrl;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        caught;
  logic        frame_tick;
  logic        video_on;
  logic [9:0]  px;
  logic [9:0]  py;
  logic [3:0]  rom_row;
  logic [4:0]  rom_col;
  logic [11:0] rom_data;
  logic        fish_on;
  logic [11:0] rgb;
  logic [9:0]  fish_x;
  logic [9:0]  fish_y;
  logic [1:0]  state;

  fish_sprite_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .caught     (caught),
    .frame_tick (frame_tick),
    .video_on   (video_on),
    .x          (px),
    .y          (py),
    .rom_row    (rom_row),
    .rom_col    (rom_col),
    .rom_data   (rom_data),
    .fish_on    (fish_on),
    .rgb        (rgb),
    .fish_x     (fish_x),
    .fish_y     (fish_y),
    .state      (state)
  );

  // ---------------- clock / reset / cycle count ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // ---------------- ROM model ----------------
  logic [11:0] rom_mem [0:15][0:31];
  always @(posedge clk) rom_data <= rom_mem[rom_row][rom_col];

  // ---------------- scoreboard ----------------
  logic [12:0] exp_q[$];
  int          due_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  // Reference position/state, advanced by the tick driver from the rules.
  int m_x  = 0;
  int m_y  = 240;
  int m_st = 0;

  function automatic logic [12:0] exp_pix(int xx, int yy, bit vo);
    int          ddx;
    int          ddy;
    int          col;
    logic [11:0] d;
    ddx = xx - m_x;
    ddy = yy - m_y;
    if (ddx < 0 || ddx >= 32 || ddy < 0 || ddy >= 16) return 13'd0;
    col = (m_st == 2) ? ddx : 31 - ddx;
    d = rom_mem[ddy][col];
    if (vo && m_st != 0 && d != 12'hFFF) return {1'b1, d};
    return 13'd0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic pixel_drive(input int xx, input int yy, input bit vo);
    logic [12:0] e;
    @(negedge clk);
    if (due_q.size() > 0 && due_q[0] <= cyc) begin
      e = exp_q.pop_front();
      void'(due_q.pop_front());
      n_cmp++;
      if ({fish_on, rgb} !== e) begin
        n_err++;
        $display("FAIL pixel: got on=%b rgb=%h, want on=%b rgb=%h",
                 fish_on, rgb, e[12], e[11:0]);
      end
    end
    px       = 10'(xx);
    py       = 10'(yy);
    video_on = vo;
    exp_q.push_back(exp_pix(xx, yy, vo));
    due_q.push_back(cyc + 2);
  endtask

  task automatic pixel_drain();
    logic [12:0] e;
    int          guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(negedge clk);
      px       = 10'd1023;
      py       = 10'd1023;
      video_on = 1'b0;
      if (due_q.size() > 0 && due_q[0] <= cyc) begin
        e = exp_q.pop_front();
        void'(due_q.pop_front());
        n_cmp++;
        if ({fish_on, rgb} !== e) begin
          n_err++;
          $display("FAIL pixel: got on=%b rgb=%h, want on=%b rgb=%h",
                   fish_on, rgb, e[12], e[11:0]);
        end
      end
      guard++;
    end
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d pixels never compared, want 0", exp_q.size());
      exp_q.delete();
      due_q.delete();
    end
  endtask

  task automatic pixel_random(input int n);
    for (int i = 0; i < n; i++) begin
      int xx;
      int yy;
      xx = m_x + int'($urandom_range(0, 40)) - 4;
      yy = m_y + int'($urandom_range(0, 21)) - 3;
      if (xx < 0) xx = 0;
      pixel_drive(xx, yy, ($urandom_range(0, 7) != 0));
    end
  endtask

  // Drive caught/frame_tick for one cycle; returns at the negedge after the
  // update so the caller can check position and state.
  task automatic tick(input bit c, input bit t);
    @(negedge clk);
    caught     = c;
    frame_tick = t;
    case (m_st)
      0: if (t) begin m_st = 1; m_x = 2; end
      1: if (c) m_st = 3;
         else if (t) begin
           if (m_x + 2 >= 608) begin m_x = 608; m_st = 2; end
           else m_x = m_x + 2;
         end
      2: if (c) m_st = 3;
         else if (t) begin
           if (m_x <= 2) begin m_x = 0; m_st = 1; end
           else m_x = m_x - 2;
         end
      default: if (t) begin
           if (m_y <= 34) begin m_st = 0; m_x = 0; m_y = 240; end
           else m_y = m_y - 2;
         end
    endcase
    @(negedge clk);
    caught     = 1'b0;
    frame_tick = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset    = 1'b1;
    enable   = 1'b1;
    video_on = 1'b1;
    px       = 10'd5;
    py       = 10'd243;
    repeat (3) @(negedge clk);
    n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", state); end
    n_cmp++; if (fish_x !== 10'd0) begin n_err++; $display("FAIL reset_x: got %0d want 0", fish_x); end
    n_cmp++; if (fish_y !== 10'd240) begin n_err++; $display("FAIL reset_y: got %0d want 240", fish_y); end
    n_cmp++; if (fish_on !== 1'b0) begin n_err++; $display("FAIL reset_on: got %b want 0", fish_on); end
    n_cmp++; if (rgb !== 12'h000) begin n_err++; $display("FAIL reset_rgb: got %h want 000", rgb); end
    reset    = 1'b0;
    video_on = 1'b0;
    m_st = 0; m_x = 0; m_y = 240;
  endtask

  task automatic test_idle_hidden();
    pixel_drive(5, 243, 1'b1);
    pixel_drive(0, 240, 1'b1);
    pixel_drive(31, 255, 1'b1);
    pixel_drain();
    n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL idle_hold: got %0d want 0", state); end
  endtask

  task automatic test_start();
    tick(1'b0, 1'b1);
    n_cmp++; if (state !== 2'd1) begin n_err++; $display("FAIL start_state: got %0d want 1", state); end
    n_cmp++; if (fish_x !== 10'd2) begin n_err++; $display("FAIL start_x: got %0d want 2", fish_x); end
    n_cmp++; if (fish_y !== 10'd240) begin n_err++; $display("FAIL start_y: got %0d want 240", fish_y); end
  endtask

  task automatic test_pixel_swim_r();
    pixel_drive(7, 243, 1'b1);
    #1;
    n_cmp++; if (rom_col !== 5'd26) begin n_err++; $display("FAIL swim_r_col: got %0d want 26", rom_col); end
    n_cmp++; if (rom_row !== 4'd3) begin n_err++; $display("FAIL swim_r_row: got %0d want 3", rom_row); end
    pixel_drive(12, 245, 1'b1);   // col 21 row 5 holds white
    pixel_drive(34, 243, 1'b1);   // one past the right edge
    pixel_drive(1, 243, 1'b1);    // one left of the box
    pixel_random(30);
    pixel_drain();
  endtask

  task automatic test_edge_right();
    int guard;
    guard = 0;
    while (m_x < 606 && guard < 400) begin
      tick(1'b0, 1'b1);
      n_cmp++; if (fish_x !== 10'(m_x)) begin n_err++; $display("FAIL swim_r_x: got %0d want %0d", fish_x, m_x); end
      guard++;
    end
    n_cmp++; if (state !== 2'd1) begin n_err++; $display("FAIL pre_edge_state: got %0d want 1", state); end
    tick(1'b0, 1'b1);
    n_cmp++; if (fish_x !== 10'd608) begin n_err++; $display("FAIL edge_x: got %0d want 608", fish_x); end
    n_cmp++; if (state !== 2'd2) begin n_err++; $display("FAIL edge_state: got %0d want 2", state); end
    tick(1'b0, 1'b1);
    n_cmp++; if (fish_x !== 10'd606) begin n_err++; $display("FAIL turn_x: got %0d want 606", fish_x); end
    n_cmp++; if (state !== 2'd2) begin n_err++; $display("FAIL turn_state: got %0d want 2", state); end
  endtask

  task automatic test_pixel_swim_l();
    int guard;
    guard = 0;
    while (m_x > 2 && guard < 400) begin
      tick(1'b0, 1'b1);
      n_cmp++; if (fish_x !== 10'(m_x)) begin n_err++; $display("FAIL swim_l_x: got %0d want %0d", fish_x, m_x); end
      guard++;
    end
    n_cmp++; if (state !== 2'd2) begin n_err++; $display("FAIL swim_l_state: got %0d want 2", state); end
    pixel_drive(7, 243, 1'b1);    // grey 777 at row 3 col 5
    #1;
    n_cmp++; if (rom_col !== 5'd5) begin n_err++; $display("FAIL swim_l_col: got %0d want 5", rom_col); end
    n_cmp++; if (rom_row !== 4'd3) begin n_err++; $display("FAIL swim_l_row: got %0d want 3", rom_row); end
    pixel_drive(8, 244, 1'b1);    // black, opaque
    pixel_drive(12, 245, 1'b1);   // white, transparent
    pixel_drive(34, 243, 1'b1);   // x = fish_x + 32
    pixel_drive(7, 243, 1'b0);    // blanking
    pixel_random(30);
    pixel_drain();
  endtask

  task automatic test_wrap_left();
    tick(1'b0, 1'b1);
    n_cmp++; if (fish_x !== 10'd0) begin n_err++; $display("FAIL wrap_x: got %0d want 0", fish_x); end
    n_cmp++; if (state !== 2'd1) begin n_err++; $display("FAIL wrap_state: got %0d want 1", state); end
  endtask

  task automatic test_caught_hooked();
    int n_ticks;
    tick(1'b1, 1'b1);
    n_cmp++; if (state !== 2'd3) begin n_err++; $display("FAIL hook_state: got %0d want 3", state); end
    n_cmp++; if (fish_x !== 10'd0) begin n_err++; $display("FAIL hook_x: got %0d want 0", fish_x); end
    n_cmp++; if (fish_y !== 10'd240) begin n_err++; $display("FAIL hook_y: got %0d want 240", fish_y); end
    tick(1'b1, 1'b0);
    n_cmp++; if (state !== 2'd3) begin n_err++; $display("FAIL hook_recaught: got %0d want 3", state); end
    n_ticks = 0;
    while (m_st == 3 && n_ticks < 150) begin
      tick(1'b0, 1'b1);
      n_ticks++;
      n_cmp++; if (fish_y !== 10'(m_y)) begin n_err++; $display("FAIL rise_y: got %0d want %0d", fish_y, m_y); end
    end
    n_cmp++; if (n_ticks !== 104) begin n_err++; $display("FAIL rise_ticks: got %0d want 104", n_ticks); end
    n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL surface_state: got %0d want 0", state); end
    n_cmp++; if (fish_y !== 10'd240) begin n_err++; $display("FAIL surface_y: got %0d want 240", fish_y); end
    tick(1'b1, 1'b0);
    n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL idle_caught: got %0d want 0", state); end
  endtask

  task automatic test_enable_off();
    tick(1'b0, 1'b1);
    repeat (4) tick(1'b0, 1'b1);
    n_cmp++; if (fish_x !== 10'd10) begin n_err++; $display("FAIL en_x: got %0d want 10", fish_x); end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b1);
    n_cmp++; if (fish_x !== 10'd10) begin n_err++; $display("FAIL freeze_x: got %0d want 10", fish_x); end
    n_cmp++; if (fish_y !== 10'd238) begin n_err++; $display("FAIL freeze_y: got %0d want 238", fish_y); end
    enable = 1'b0;
    @(negedge clk);
    m_st = 0; m_x = 0; m_y = 240;
    n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL en_state: got %0d want 0", state); end
    n_cmp++; if (fish_y !== 10'd240) begin n_err++; $display("FAIL en_y: got %0d want 240", fish_y); end
    enable = 1'b1;
  endtask

  task automatic test_reset_midframe();
    tick(1'b0, 1'b1);
    n_cmp++; if (state !== 2'd1) begin n_err++; $display("FAIL mid_start: got %0d want 1", state); end
    px       = 10'd7;
    py       = 10'd243;
    video_on = 1'b1;
    @(negedge clk);
    reset    = 1'b1;
    video_on = 1'b0;
    @(negedge clk);
    n_cmp++; if (fish_on !== 1'b0) begin n_err++; $display("FAIL mid_on1: got %b want 0", fish_on); end
    n_cmp++; if (rgb !== 12'h000) begin n_err++; $display("FAIL mid_rgb1: got %h want 000", rgb); end
    n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL mid_state: got %0d want 0", state); end
    @(negedge clk);
    n_cmp++; if (fish_on !== 1'b0) begin n_err++; $display("FAIL mid_on2: got %b want 0", fish_on); end
    n_cmp++; if (fish_x !== 10'd0) begin n_err++; $display("FAIL mid_x: got %0d want 0", fish_x); end
    reset = 1'b0;
    m_st = 0; m_x = 0; m_y = 240;
  endtask

  // ---------------- main sequence / report ----------------
  initial begin
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 32; c++)
        rom_mem[r][c] = 12'(r * 32 + c);
    rom_mem[3][5]  = 12'h777;
    rom_mem[4][6]  = 12'h000;
    rom_mem[5][10] = 12'hFFF;
    rom_mem[5][21] = 12'hFFF;
    reset      = 1'b1;
    enable     = 1'b0;
    caught     = 1'b0;
    frame_tick = 1'b0;
    video_on   = 1'b0;
    px         = 10'd0;
    py         = 10'd0;

    test_reset();
    test_idle_hidden();
    test_start();
    test_pixel_swim_r();
    test_edge_right();
    test_pixel_swim_l();
    test_wrap_left();
    test_caught_hooked();
    test_enable_off();
    test_reset_midframe();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
